// File: rtl/key_pkg.sv
// Shared types, default timing constants and a width helper for the key
// debounce block.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_t;

  // 1 ms tick at a 50 MHz clock.
  localparam int TICK_DIV_1MS       = 50000;
  localparam int DEBOUNCE_TICKS_DEF = 20;
  localparam int LONG_TICKS_DEF     = 1000;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2_w(input int value);
    int w;
    for (w = 1; (1 << w) < value; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, polarity normalisation and the
// debounce / hold state machine with its registered pulse outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int LONG_TICKS     = LONG_TICKS_DEF,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick,
  input  logic raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DB_W   = clog2_w(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W = clog2_w(LONG_TICKS + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

  // Released level of the pin, so leaving reset looks like "not pressed".
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic              sync1;
  logic              sync2;
  logic              p;
  key_state_t        state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;

  logic hold_step;
  logic long_hit;
  logic rel_done;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= REL_LVL;
      sync2 <= REL_LVL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign p = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  assign hold_step = tick && (hold_cnt != HOLD_MAX);
  assign long_hit  = tick && (hold_cnt == HOLD_LAST) && !long_done;
  assign rel_done  = !p && tick && (db_cnt == DB_LAST);

  // Debounce FSM; all outputs registered, pulses default low every cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!p) begin
            state <= IDLE;
          end else if (tick) begin
            if (db_cnt == DB_LAST) begin
              state     <= HELD;
              key_press <= 1'b1;
              key_level <= 1'b1;
              hold_cnt  <= '0;
              long_done <= 1'b0;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
        end
        HELD: begin
          if (hold_step) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (long_hit) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
          if (!p) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end
        end
        DB_RELEASE: begin
          if (hold_step) hold_cnt <= hold_cnt + HOLD_W'(1);
          // A release accepted on this tick wins over a long-press.
          if (long_hit && !rel_done) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
          if (p) begin
            state <= HELD;
          end else if (rel_done) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else if (tick) begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Key debounce controller: shared tick prescaler plus one debounce channel
// per key, producing clean level, press, release and long-press pulses.
module key_debounce_ctrl
  import key_pkg::*;
#(
  parameter int N_KEYS         = 4,
  parameter int TICK_DIV       = TICK_DIV_1MS,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int LONG_TICKS     = LONG_TICKS_DEF,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              tick
);

  localparam int DIV_W = clog2_w(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (DEBOUNCE_TICKS < 1 || LONG_TICKS <= DEBOUNCE_TICKS || TICK_DIV < 1) begin : g_bad_params
    $error("key_debounce_ctrl: need DEBOUNCE_TICKS >= 1, LONG_TICKS > DEBOUNCE_TICKS, TICK_DIV >= 1");
  end

  logic [DIV_W-1:0] div_cnt;

  // Free-running prescaler counting 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .LONG_TICKS    (LONG_TICKS),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .nrst       (nrst),
      .tick       (tick),
      .raw        (key_raw[gi]),
      .key_level  (key_level[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi]),
      .key_long   (key_long[gi])
    );
  end

endmodule
